mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port unified RAM between the core's instruction-fetch requester and its load/store requester.
//  - Grants at most one request per cycle.
//  - Routes each read response back to its owner after the fixed RAM read latency.
//  - Guarantees fetch forward progress with a starvation counter.
//  - Sits between risc_v_core request logic and memory; replaces the ad-hoc pc/alu_out address mux.
// PARAMETERS
//  RD_LATENCY    1   cycles from mem request to valid mem_rdata (>=1)
//  STARVE_LIMIT  4   consecutive denied fetch cycles before fetch is forced to win (>=1)
// PORTS
//  clk            in   1   single clock, rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  flush          in   1   branch redirect: kill in-flight fetch responses and this cycle's fetch request
//  if_req_valid   in   1   fetch request valid
//  if_req_ready   out  1   fetch request accepted this cycle
//  if_req_addr    in   32  fetch byte address
//  if_rsp_valid   out  1   fetch read data valid
//  if_rsp_data    out  32  fetch read data
//  d_req_valid    in   1   data request valid
//  d_req_ready    out  1   data request accepted this cycle
//  d_req_we       in   1   1 = store, 0 = load
//  d_req_addr     in   32  data byte address
//  d_req_wdata    in   32  store data
//  d_rsp_valid    out  1   load data valid
//  d_rsp_data     out  32  load data
//  mem_we         out  1   RAM write enable
//  mem_addr       out  32  RAM byte address, bits [1:0] forced to 0
//  mem_wdata      out  32  RAM write data
//  mem_wdata_oe   out  1   drive mem_wdata onto the shared RAM data bus
//  mem_rdata      in   32  RAM read data
// BEHAVIOUR
//  - Reset: all outputs are 0, the tag pipe is cleared and starve_cnt is 0.
//  - Handshake: a requester holds valid, address and data stable until ready.
//    - ready is combinational, equal to that requester's grant.
//    - Transfer happens on valid & ready.
//  - Arbitration (combinational each cycle):
//    - The fetch candidate is if_req_valid & ~flush.
//    - Both candidates valid: data wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
//    - Only one candidate valid: it wins.
//  - starve_cnt (sequential):
//    - Increments when the fetch candidate is valid but not granted, saturating at STARVE_LIMIT.
//    - Clears on a fetch grant or when if_req_valid is 0.
//  - Memory drive:
//    - mem_addr is the granted address, or 0 when idle.
//    - mem_we = d grant & d_req_we; mem_wdata_oe = mem_we; mem_wdata = d_req_wdata.
//  - Tag pipe: RD_LATENCY-deep shift register of {vld, owner}.
//    - Pushes vld = 1 for every granted read (owner IF or D). Stores push vld = 0.
//    - At the pipe head, mem_rdata is routed to if_rsp_* or d_rsp_*; the other output's valid is 0.
//    - rsp_data outputs are 0 when their valid is low.
//  - Latency: a read granted at cycle N gives rsp_valid at cycle N+RD_LATENCY, in request order per owner.
//  - flush:
//    - Clears vld for every IF tag in the pipe, including a head responding the same cycle (if_rsp_valid = 0).
//    - D tags are unaffected.
//    - The data request may still be granted in the flush cycle.
//  - Reset mid-operation drops all in-flight responses; no response is emitted after rst_n deasserts for requests made before it.
//  - Throughput: 1 request per cycle, with no bubbles between back-to-back grants.
// STRUCTURE
//  - Shared package mem_pkg:
//    - typedef enum logic {OWN_IF, OWN_D} mem_owner_t
//    - typedef struct packed {logic vld; mem_owner_t owner;} mem_tag_t
//    - localparam WORD_ALIGN_MASK = 32'hFFFF_FFFC
//  - One sub-module: mem_rsp_tag_pipe (parameterised shift register of mem_tag_t with a per-owner kill input).
//  - Arbitration and starve_cnt live in the top module.
// TESTING
//  1. Reset: hold rst_n = 0 with both valids high -> all readys, rsp_valids, mem_we and mem_addr are 0.
//     Release -> first grant the next cycle.
//  2. Fetch only, addresses 0x0, 0x4, 0x8 back-to-back; RAM holds 0x000420b7, 0x04208113, 0x001001b3
//     -> if_rsp_data in order, each RD_LATENCY cycles after its grant, with no gaps.
//  3. Data wins:
//     - Both valid: load at 0x1C and fetch at 0x10 -> d granted first.
//     - d_rsp_data = 0x00000042 at N+1; the fetch is granted at N+1.
//  4. Starvation:
//     - d_req_valid held high, if_req_valid high -> fetch is denied 4 cycles.
//     - Fetch is granted on the 5th cycle; starve_cnt then returns to 0.
//  5. Flush:
//     - A fetch read is granted at N; flush at N+RD_LATENCY-0 -> if_rsp_valid stays 0.
//     - A concurrent load still returns d_rsp_valid = 1.
//     - A store at 0x7 -> mem_addr = 0x4, mem_we = 1, mem_wdata_oe = 1, and no response.
//  6. Async reset asserted mid-burst (between clock edges) -> outputs go to 0 immediately.
//     In-flight reads never respond.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the unified-RAM port arbiter: requester ownership, response
// tags and address alignment helpers.
package mem_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } mem_owner_t;

  typedef struct packed {
    logic       vld;
    mem_owner_t owner;
  } mem_tag_t;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  localparam mem_tag_t TAG_IDLE = '{vld: 1'b0, owner: OWN_IF};

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

  // Drops the valid bit of a tag whose owner is being killed.
  function automatic mem_tag_t tag_kill(input mem_tag_t tag,
                                        input logic     kill_if,
                                        input logic     kill_d);
    mem_tag_t res;
    res = tag;
    if ((tag.owner == OWN_IF && kill_if) || (tag.owner == OWN_D && kill_d)) begin
      res.vld = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response/RAM bundle between the core's two requesters, the arbiter
// and the single-port RAM.
interface mem_port_arbiter_if;

  logic        flush;

  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;

  logic        d_req_valid;
  logic        d_req_ready;
  logic        d_req_we;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wdata_oe;
  logic [31:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  flush,
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output mem_we, mem_addr, mem_wdata, mem_wdata_oe,
    input  mem_rdata
  );

  // Core requesters plus RAM.
  modport master (
    output flush,
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  mem_we, mem_addr, mem_wdata, mem_wdata_oe,
    output mem_rdata
  );

endinterface

// File: rtl/mem_rsp_tag_pipe.sv
// Fixed-depth shift register of response tags; the head tag says who owns the
// RAM read data this cycle. Per-owner kill clears valids in every stage.
module mem_rsp_tag_pipe
  import mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  mem_tag_t i_push,
  input  logic     i_kill_if,
  input  logic     i_kill_d,
  output mem_tag_t o_head
);

  mem_tag_t r_stage [DEPTH];

  // NOTE: the tag stages are reset, unlike RAM-style storage, because a stale
  // vld surviving reset would emit a phantom response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= TAG_IDLE;
      end
    end else begin
      // NOTE: non-blocking assignments make every stage sample its
      // predecessor's old value, which is what makes this a shift register.
      r_stage[0] <= tag_kill(i_push, i_kill_if, i_kill_d);
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= tag_kill(r_stage[i-1], i_kill_if, i_kill_d);
      end
    end
  end

  // The head is also killed combinationally so a flush suppresses a response
  // landing in the flush cycle itself.
  assign o_head = tag_kill(r_stage[DEPTH-1], i_kill_if, i_kill_d);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-port unified RAM: data wins by default,
// a starvation counter forces fetch through, read data is routed by tag.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve_cnt;

  logic     w_if_cand;
  logic     w_d_cand;
  logic     w_grant_if;
  logic     w_grant_d;
  logic     w_d_read;
  mem_tag_t w_push;
  mem_tag_t w_head;
  logic     w_rsp_if;
  logic     w_rsp_d;

  assign w_if_cand = bus.if_req_valid & ~bus.flush;
  assign w_d_cand  = bus.d_req_valid;

  // Grants are gated by rst_n so every output reads 0 while reset is held.
  // NOTE: both grants get a default before any branch, so no path leaves
  // them unassigned and no latch is inferred.
  always_comb begin
    w_grant_if = 1'b0;
    w_grant_d  = 1'b0;
    if (rst_n) begin
      if (w_if_cand && w_d_cand) begin
        if (r_starve_cnt == CNT_MAX) w_grant_if = 1'b1;
        else                         w_grant_d  = 1'b1;
      end else if (w_if_cand) begin
        w_grant_if = 1'b1;
      end else if (w_d_cand) begin
        w_grant_d = 1'b1;
      end
    end
  end

  // Counts consecutive cycles a live fetch candidate lost arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!bus.if_req_valid || w_grant_if) begin
      r_starve_cnt <= '0;
    end else if (w_if_cand && r_starve_cnt != CNT_MAX) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  assign bus.if_req_ready = w_grant_if;
  assign bus.d_req_ready  = w_grant_d;

  assign bus.mem_addr     = w_grant_if ? word_align(bus.if_req_addr) :
                            w_grant_d  ? word_align(bus.d_req_addr)  : 32'h0;
  assign bus.mem_we       = w_grant_d & bus.d_req_we;
  assign bus.mem_wdata_oe = bus.mem_we;
  assign bus.mem_wdata    = rst_n ? bus.d_req_wdata : 32'h0;

  // Stores occupy the RAM slot but push an invalid tag: they never respond.
  assign w_d_read     = w_grant_d & ~bus.d_req_we;
  assign w_push.vld   = w_grant_if | w_d_read;
  assign w_push.owner = w_grant_if ? OWN_IF : OWN_D;

  mem_rsp_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_kill_if (bus.flush),
    .i_kill_d  (1'b0),
    .o_head    (w_head)
  );

  assign w_rsp_if = w_head.vld & (w_head.owner == OWN_IF);
  assign w_rsp_d  = w_head.vld & (w_head.owner == OWN_D);

  assign bus.if_rsp_valid = w_rsp_if;
  assign bus.if_rsp_data  = w_rsp_if ? bus.mem_rdata : 32'h0;
  assign bus.d_rsp_valid  = w_rsp_d;
  assign bus.d_rsp_data   = w_rsp_d ? bus.mem_rdata : 32'h0;

endmodule
